mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
//  Multi-cycle MIPS main controller: Moore FSM that sequences the shared ALU, memory port and regfile.
//  Decodes opcode/funct into per-cycle mux selects (mux2/mux4) and flip_flop write enables.
//  Sits beside the datapath; its only input from the datapath is the ALU zero flag.
// PARAMETERS
//  (none)
// PORTS
//  clk          in   1  clock; all state updates on posedge
//  rst          in   1  reset, synchronous, active-high
//  opcode       in   6  instr[31:26], taken from the IR register
//  funct        in   6  instr[5:0], taken from the IR register
//  zero         in   1  ALU zero flag (same cycle)
//  pc_we        out  1  PC register enable = pc_write | (branch & zero)
//  ir_we        out  1  IR register enable
//  mem_we       out  1  memory write strobe
//  reg_we       out  1  register file write enable
//  iord         out  1  memory address: 0=PC, 1=ALUOut
//  mem_to_reg   out  1  writeback data: 0=ALUOut, 1=MDR
//  reg_dst      out  1  destination register: 0=rt, 1=rd
//  alu_src_a    out  1  ALU A: 0=PC, 1=regA
//  alu_src_b    out  2  ALU B: 00=regB, 01=4, 10=imm, 11=imm<<2
//  imm_zext     out  1  immediate extension: 0=sign_extension, 1=unsign_extension
//  pc_src       out  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
//  alu_ctrl     out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  state        out  4  current state (debug/visibility)
// BEHAVIOUR
//  - Clock: clk. Reset: rst. Reset is synchronous and active-high.
//  - State register: reset state FETCH. All outputs decode from state only (Moore), except the zero term of pc_we.
//  - While rst=1: every output is 0 and state reads 0 (FETCH encoding).
//  - States and transitions:
//    FETCH(0): iord=0, ir_we=1, src_a=0, src_b=01, add, pc_src=00, pc_write -> DECODE.
//    DECODE(1): src_a=0, src_b=11, add (branch target into ALUOut). Then by opcode:
//      LW 100011 / SW 101011 -> MEMADR.   R-type 000000 -> RTYPEEX.   BEQ 000100 -> BEQEX.
//      ADDI 001000 -> ADDIEX.   J 000010 -> JEX.   Any other opcode -> FETCH (executed as NOP).
//    MEMADR(2): src_a=1, src_b=10, add -> MEMRD (LW) or MEMWR (SW).
//    MEMRD(3): iord=1 -> MEMWB.
//    MEMWB(4): reg_we=1, reg_dst=0, mem_to_reg=1 -> FETCH.
//    MEMWR(5): iord=1, mem_we=1 -> FETCH.
//    RTYPEEX(6): src_a=1, src_b=00, alu_ctrl from funct -> RTYPEWB.
//      funct map: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct -> add.
//    RTYPEWB(7): reg_we=1, reg_dst=1, mem_to_reg=0 -> FETCH.
//    BEQEX(8): src_a=1, src_b=00, sub, pc_src=01, branch=1 -> FETCH.
//    ADDIEX(9): src_a=1, src_b=10, add -> ADDIWB.
//    ADDIWB(10): reg_we=1, reg_dst=0, mem_to_reg=0 -> FETCH.
//    JEX(11): pc_src=10, pc_write -> FETCH.
//  - Instruction latency in cycles, FETCH included: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3, illegal 2.
//  - Every unlisted output is 0 in every state. imm_zext=0 unless stated otherwise.
//  - An unused state encoding is recovered to FETCH on the next edge, with all outputs 0 while in it.
//  - rst asserted in any state: state is FETCH after that edge. No partial write occurs, because outputs are forced to 0 while rst=1.
// CONFIGURATION
//  - LOGIC_IMM_EN defined: adds LOGIEX(12), src_a=1, src_b=10, imm_zext=1.
//    ANDI 001100 -> LOGIEX with and; ORI 001101 -> LOGIEX with or. LOGIEX -> ADDIWB.
//  - LOGIC_IMM_EN undefined: ANDI/ORI are illegal opcodes (NOP). State 12 is unused. imm_zext is tied to 0.
// TESTING
//  - Reset: hold rst 2 cycles -> all outputs 0, state=0. First cycle after release: ir_we=1, pc_we=1, src_b=01.
//  - LW (op 100011): state sequence 0,1,2,3,4. In state 4: reg_we=1, mem_to_reg=1. Exactly 5 cycles.
//  - SW then R-type sub (funct 100010): SW gives mem_we=1 only in state 5. R-type gives alu_ctrl=110 in state 6 and reg_we=1, reg_dst=1 in state 7.
//  - BEQ with zero=1 -> pc_we=1 and pc_src=01 in state 8. Repeat with zero=0 -> pc_we=0. J -> pc_src=10 and pc_we=1 in state 11.
//  - Illegal opcode 111111 -> states 0,1,0. Assert rst while in state 3 -> outputs 0 and state 0 on the next cycle.
//  - With LOGIC_IMM_EN, ORI 001101 -> states 0,1,12,10 with imm_zext=1 and alu_ctrl=001 in state 12. Without the macro -> NOP.

Source files
------------

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS main controller (Moore FSM).
// Sequences the shared ALU, memory port and register file by decoding the
// IR opcode/funct into per-cycle mux selects and write enables.
// Optional feature: define LOGIC_IMM_EN to add ANDI/ORI support (LOGIEX
// state, zero-extended immediate). Without it ANDI/ORI execute as NOPs and
// imm_zext is constant 0.
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_we,
  output logic       ir_we,
  output logic       mem_we,
  output logic       reg_we,
  output logic       iord,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       imm_zext,
  output logic [1:0] pc_src,
  output logic [2:0] alu_ctrl,
  output logic [3:0] state
);

  // State encodings (visible on the state port).
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
`ifdef LOGIC_IMM_EN
  localparam logic [3:0] S_LOGIEX  = 4'd12;
`endif

  // Opcodes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef LOGIC_IMM_EN
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

  // ALU operations.
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [2:0] funct_alu;

  // R-type funct to ALU operation; unknown functs fall back to add.
  always_comb begin
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      default:   funct_alu = ALU_ADD;
    endcase
  end

  // State register with synchronous reset to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused encodings fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef LOGIC_IMM_EN
          OP_ANDI, OP_ORI: state_d = S_LOGIEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
`ifdef LOGIC_IMM_EN
      S_LOGIEX:  state_d = S_ADDIWB;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore output decode; everything is forced to 0 while rst is high.
  always_comb begin
    logic pc_write;
    logic branch;
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    imm_zext   = 1'b0;
    pc_src     = 2'b00;
    alu_ctrl   = 3'b000;
    case (state_q)
      S_FETCH: begin
        ir_we     = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        pc_write  = 1'b1;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord   = 1'b1;
        mem_we = 1'b1;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_alu;
      end
      S_RTYPEWB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      S_BEQEX: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = ALU_ADD;
      end
      S_ADDIWB: reg_we = 1'b1;
      S_JEX: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
`ifdef LOGIC_IMM_EN
      S_LOGIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        imm_zext  = 1'b1;
        alu_ctrl  = (opcode == OP_ORI) ? ALU_OR : ALU_AND;
      end
`endif
      default: ;
    endcase

    pc_we = pc_write | (branch & zero);
    state = state_q;

    if (rst) begin
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      iord       = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      imm_zext   = 1'b0;
      pc_src     = 2'b00;
      alu_ctrl   = 3'b000;
      state      = S_FETCH;
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed instructions followed by
// random ones, each compared cycle by cycle against a per-instruction
// reference of visited steps and the control word expected in each step.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_we, ir_we, mem_we, reg_we, iord, mem_to_reg, reg_dst;
  logic       alu_src_a, imm_zext;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;
  int exp_seq[$];

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_we(pc_we), .ir_we(ir_we), .mem_we(mem_we), .reg_we(reg_we),
    .iord(iord), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext),
    .pc_src(pc_src), .alu_ctrl(alu_ctrl), .state(state)
  );

  always #5 clk = ~clk;

  // Observed control word, packed in a fixed field order.
  wire [15:0] ctrl_obs = {pc_we, ir_we, mem_we, reg_we, iord, mem_to_reg, reg_dst,
                          alu_src_a, alu_src_b, imm_zext, pc_src, alu_ctrl};

  // Expected control word for one instruction step, from the step's role.
  function automatic logic [15:0] ctrl_word(input int st, input logic [5:0] op,
                                            input logic [5:0] fn, input logic z);
    logic pcw = 0, irw = 0, mw = 0, rw = 0, io = 0, m2r = 0, rd = 0, sa = 0, zx = 0;
    logic [1:0] sb = 0, ps = 0;
    logic [2:0] ac = 0;
    case (st)
      0:  begin irw = 1; sb = 2'b01; ac = 3'b010; pcw = 1; end
      1:  begin sb = 2'b11; ac = 3'b010; end
      2:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      3:  io = 1;
      4:  begin rw = 1; m2r = 1; end
      5:  begin io = 1; mw = 1; end
      6:  begin
            sa = 1;
            if (fn == 6'b100010)      ac = 3'b110;
            else if (fn == 6'b100100) ac = 3'b000;
            else if (fn == 6'b100101) ac = 3'b001;
            else if (fn == 6'b101010) ac = 3'b111;
            else                      ac = 3'b010;
          end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pcw = z; end
      9:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
      10: rw = 1;
      11: begin ps = 2'b10; pcw = 1; end
`ifdef LOGIC_IMM_EN
      12: begin sa = 1; sb = 2'b10; zx = 1; ac = (op == 6'b001101) ? 3'b001 : 3'b000; end
`endif
      default: ;
    endcase
    return {pcw, irw, mw, rw, io, m2r, rd, sa, sb, zx, ps, ac};
  endfunction

  // Steps an instruction visits, FETCH included.
  task automatic load_seq(input logic [5:0] op);
    case (op)
      6'b100011: exp_seq = '{0, 1, 2, 3, 4};
      6'b101011: exp_seq = '{0, 1, 2, 5};
      6'b000000: exp_seq = '{0, 1, 6, 7};
      6'b000100: exp_seq = '{0, 1, 8};
      6'b001000: exp_seq = '{0, 1, 9, 10};
      6'b000010: exp_seq = '{0, 1, 11};
`ifdef LOGIC_IMM_EN
      6'b001100, 6'b001101: exp_seq = '{0, 1, 12, 10};
`endif
      default:   exp_seq = '{0, 1};
    endcase
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one instruction from FETCH; zmode 0/1 forces zero, 2 randomizes it.
  // Called at posedge+1 with the DUT in FETCH; returns the same way.
  task automatic run_instr(input string tag, input logic [5:0] op,
                           input logic [5:0] fn, input int zmode);
    opcode = op;
    funct  = fn;
    load_seq(op);
    foreach (exp_seq[i]) begin
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      #1;
      chk({tag, "_state"}, {12'd0, state}, 16'(exp_seq[i]));
      chk({tag, "_ctrl"}, ctrl_obs, ctrl_word(exp_seq[i], op, fn, zero));
      @(posedge clk);
      #1;
    end
    chk({tag, "_end_fetch"}, {12'd0, state}, 16'd0);
    $display("instr %s op=%b funct=%b cycles=%0d", tag, op, fn, exp_seq.size());
  endtask

  logic [5:0] rand_ops [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                               6'b001000, 6'b000010, 6'b001100, 6'b001101};
  logic [5:0] rand_fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    rst = 1'b1; opcode = 6'b100011; funct = 6'b100010; zero = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", ctrl_obs, 16'd0);
    chk("reset_state", {12'd0, state}, 16'd0);
    rst = 1'b0;
    #1;
    chk("release_fetch", ctrl_obs, ctrl_word(0, opcode, funct, zero));
    $display("reset released, fetch word=%h", ctrl_obs);

    run_instr("lw", 6'b100011, 6'b000000, 2);
    run_instr("sw", 6'b101011, 6'b000000, 2);
    run_instr("r_sub", 6'b000000, 6'b100010, 2);
    run_instr("r_slt", 6'b000000, 6'b101010, 2);
    run_instr("r_badfn", 6'b000000, 6'b111111, 2);
    run_instr("beq_taken", 6'b000100, 6'b000000, 1);
    run_instr("beq_not", 6'b000100, 6'b000000, 0);
    run_instr("addi", 6'b001000, 6'b000000, 2);
    run_instr("j", 6'b000010, 6'b000000, 2);
    run_instr("illegal", 6'b111111, 6'b000000, 2);
    run_instr("ori", 6'b001101, 6'b000000, 2);
    run_instr("andi", 6'b001100, 6'b000000, 2);

    // Reset asserted mid-LW while in MEMRD.
    opcode = 6'b100011;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_pre_state", {12'd0, state}, 16'd3);
    rst = 1'b1;
    #1;
    chk("midrst_ctrl_now", ctrl_obs, 16'd0);
    @(posedge clk);
    #1;
    chk("midrst_ctrl", ctrl_obs, 16'd0);
    chk("midrst_state", {12'd0, state}, 16'd0);
    rst = 1'b0;
    #1;
    chk("midrst_release", ctrl_obs, ctrl_word(0, opcode, funct, zero));
    $display("reset during MEMRD recovered to fetch");

    for (int n = 0; n < 60; n++) begin
      int k;
      k = int'($urandom_range(0, 8));
      op = (k == 8) ? 6'($urandom) : rand_ops[k];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : rand_fns[$urandom_range(0, 4)];
      run_instr("rand", op, fn, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
